// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Performs inhibit / request-to-send, shifts out 8 data bits, odd parity
// and stop on device-generated clocks, then checks the device ACK.
// The block only drives output enables; external open-drain pads pull low.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned RTS_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       kclk_in,
  input  logic       kdata_in,
  output logic       kclk_oe,
  output logic       kdata_oe
);

  localparam int unsigned PH_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PH_W-1:0] INH_LAST = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0] RTS_LAST = PH_W'(RTS_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t          state;
  logic [PH_W-1:0] ph_cnt;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      bit_cnt;
  logic [9:0]      frame;

  logic kclk_s1, kclk_s2, kclk_prev;
  logic kdata_s1, kdata_s2;
  logic kclk_fall;

  // Two-flop synchronizers for both pins plus one history flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kclk_s1   <= 1'b1;
      kclk_s2   <= 1'b1;
      kclk_prev <= 1'b1;
      kdata_s1  <= 1'b1;
      kdata_s2  <= 1'b1;
    end else begin
      kclk_s1   <= kclk_in;
      kclk_s2   <= kclk_s1;
      kclk_prev <= kclk_s2;
      kdata_s1  <= kdata_in;
      kdata_s2  <= kdata_s1;
    end
  end

  assign kclk_fall = kclk_prev & ~kclk_s2;

  // Transfer sequencer: inhibit, request-to-send, bit shifting, ACK check, bus idle wait
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ph_cnt   <= '0;
      to_cnt   <= '0;
      bit_cnt  <= '0;
      frame    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      kclk_oe  <= 1'b0;
      kdata_oe <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            // Frame is shifted out LSB first: data[7:0], odd parity, stop.
            frame    <= {1'b1, ~^tx_data, tx_data};
            busy     <= 1'b1;
            kclk_oe  <= 1'b1;
            kdata_oe <= 1'b0;
            ph_cnt   <= '0;
            state    <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (ph_cnt == INH_LAST) begin
            ph_cnt   <= '0;
            kdata_oe <= 1'b1;
            state    <= S_RTS;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        S_RTS: begin
          if (ph_cnt == RTS_LAST) begin
            ph_cnt  <= '0;
            kclk_oe <= 1'b0;
            to_cnt  <= '0;
            bit_cnt <= '0;
            state   <= S_SEND;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end

        S_SEND, S_ACK, S_WAIT_IDLE: begin
          if (to_cnt == TO_LAST) begin
            kclk_oe  <= 1'b0;
            kdata_oe <= 1'b0;
            busy     <= 1'b0;
            error    <= 1'b1;
            state    <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (state == S_SEND) begin
              if (kclk_fall) begin
                kdata_oe <= ~frame[0];
                frame    <= {1'b0, frame[9:1]};
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == 4'd9) begin
                  state <= S_ACK;
                end
              end
            end else if (state == S_ACK) begin
              if (kclk_fall) begin
                if (kdata_s2) begin
                  kclk_oe  <= 1'b0;
                  kdata_oe <= 1'b0;
                  busy     <= 1'b0;
                  error    <= 1'b1;
                  state    <= S_IDLE;
                end else begin
                  state <= S_WAIT_IDLE;
                end
              end
            end else begin
              if (kclk_s2 && kdata_s2) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_IDLE;
              end
            end
          end
        end

        default: begin
          kclk_oe  <= 1'b0;
          kdata_oe <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
